// File: rtl/tilebuffer_feeder_pkg.sv
// cutie_feeder_pkg: shared state encoding and default geometry for the tile buffer feeder
package cutie_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } feeder_state_e;

    localparam int unsigned N_I_DEF       = 256;
    localparam int unsigned K_DEF         = 3;
    localparam int unsigned MAX_IMG_W_DEF = 64;
    localparam int unsigned MAX_IMG_H_DEF = 64;
    localparam int unsigned PAD_W         = K_DEF / 2;
    localparam int unsigned CW            = $clog2(MAX_IMG_W_DEF + 1);
    localparam int unsigned RW            = $clog2(MAX_IMG_H_DEF + 1);

endpackage

// File: rtl/tilebuffer_feeder.sv
// tilebuffer_feeder: streams one padded image row at a time into a K-deep shift tile buffer and flags stride-aligned windows
module tilebuffer_feeder
    import cutie_feeder_pkg::*;
#(
    parameter int unsigned N_I       = N_I_DEF,
    parameter int unsigned K         = K_DEF,
    parameter int unsigned MAX_IMG_W = MAX_IMG_W_DEF,
    parameter int unsigned MAX_IMG_H = MAX_IMG_H_DEF,
    localparam int unsigned COL_W    = $clog2(MAX_IMG_W + 1),
    localparam int unsigned ROW_W    = $clog2(MAX_IMG_H + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [COL_W-1:0]   img_width_i,
    input  logic [ROW_W-1:0]   img_height_i,
    input  logic               padding_i,
    input  logic [1:0]         stride_i,
    input  logic [2*N_I-1:0]   pixel_i,
    input  logic               pixel_valid_i,
    output logic               pixel_ready_o,
    output logic [2*N_I-1:0]   tb_data_o,
    output logic               tb_save_enable_o,
    output logic               tb_flush_o,
    output logic               window_valid_o,
    input  logic               window_ready_i,
    output logic [COL_W-1:0]   window_col_o,
    output logic [ROW_W-1:0]   window_row_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int unsigned IW     = COL_W + 1;
    localparam int unsigned FILL_W = $clog2(K + 1);
    localparam logic [IW-1:0]     PAD_V = IW'(K / 2);
    localparam logic [IW-1:0]     K_V   = IW'(K);
    localparam logic [FILL_W-1:0] K_F   = FILL_W'(K);

    feeder_state_e     state_q, state_d;
    logic [IW-1:0]     col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              win_q, win_d;
    logic [COL_W-1:0]  width_q;
    logic [ROW_W-1:0]  height_q;
    logic              pad_q;
    logic              stride2_q;

    logic [IW-1:0]     pad_amt, row_len, w_cur, w_idx;
    logic [FILL_W-1:0] fill_inc;
    logic              in_pad, stall, feeding, push, new_win;

    // datapath helpers derived from the current counters and latched config
    always_comb begin
        pad_amt  = pad_q ? PAD_V : '0;
        row_len  = {1'b0, width_q} + (pad_amt << 1);
        in_pad   = (col_q < pad_amt) || (col_q >= pad_amt + {1'b0, width_q});
        stall    = win_q && !window_ready_i;
        feeding  = state_q == ST_FEED;
        push     = feeding && !stall && (in_pad || pixel_valid_i);
        fill_inc = (fill_q == K_F) ? K_F : fill_q + 1'b1;
        // K is odd, so the parity of col_q-(K-1) equals the parity of col_q
        new_win  = (fill_inc == K_F) && (!stride2_q || !col_q[0]);
        w_cur    = col_q - K_V;
        w_idx    = stride2_q ? (w_cur >> 1) : w_cur;
    end

    // next-state logic for the row sequencer and window handshake
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        fill_d     = fill_q;
        win_d      = win_q && !window_ready_i;
        tb_flush_o = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FLUSH;
                    row_d   = '0;
                end
            end
            ST_FLUSH: begin
                tb_flush_o = 1'b1;
                col_d      = '0;
                fill_d     = '0;
                state_d    = ST_FEED;
            end
            ST_FEED: begin
                if (push) begin
                    col_d  = col_q + 1'b1;
                    fill_d = fill_inc;
                    win_d  = new_win;
                    if (col_q == row_len - 1'b1) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!stall) begin
                    if (row_q == height_q - 1'b1) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // tile buffer and window outputs; everything idles at zero outside FEED/held windows
    always_comb begin
        tb_save_enable_o = push;
        pixel_ready_o    = push && !in_pad;
        tb_data_o        = (feeding && !in_pad) ? pixel_i : '0;
        window_valid_o   = win_q;
        window_col_o     = win_q ? COL_W'(w_idx) : '0;
        window_row_o     = win_q ? row_q : '0;
        busy_o           = state_q != ST_IDLE;
    end

    // state and counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            fill_q  <= '0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            fill_q  <= fill_d;
            win_q   <= win_d;
        end
    end

    // image configuration captured when an image is started
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            width_q   <= '0;
            height_q  <= '0;
            pad_q     <= 1'b0;
            stride2_q <= 1'b0;
        end else if (state_q == ST_IDLE && start_i) begin
            width_q   <= img_width_i;
            height_q  <= img_height_i;
            pad_q     <= padding_i;
            stride2_q <= stride_i == 2'd2;
        end
    end

endmodule

// File: tb/tb_tilebuffer_feeder.sv
// tb_tilebuffer_feeder: randomized scoreboard bench with a shift tile buffer behind the feeder
module tb_tilebuffer_feeder;

    localparam int NI    = 4;
    localparam int K     = 3;
    localparam int PW    = 2 * NI;
    localparam int CW    = 7;
    localparam int RW    = 7;
    localparam int DW    = K * PW;
    localparam int LIMIT = 5000;

    typedef struct packed {
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic [DW-1:0] data;
    } win_t;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic [CW-1:0] img_width_i = '0;
    logic [RW-1:0] img_height_i = '0;
    logic          padding_i = 1'b0;
    logic [1:0]    stride_i = '0;
    logic [PW-1:0] pixel_i = '0;
    logic          pixel_valid_i = 1'b0;
    logic          pixel_ready_o;
    logic [PW-1:0] tb_data_o;
    logic          tb_save_enable_o;
    logic          tb_flush_o;
    logic          window_valid_o;
    logic          window_ready_i = 1'b0;
    logic [CW-1:0] window_col_o;
    logic [RW-1:0] window_row_o;
    logic          busy_o;
    logic          done_o;

    logic [DW-1:0] tbuf;
    win_t          exp_q[$];
    logic [PW-1:0] stream[$];
    int            idx, flush_cnt, done_cnt;
    bit            abort;
    int            checks = 0;
    int            failures = 0;
    bit            hold;
    win_t          held;

    always #5 clk = ~clk;

    tilebuffer_feeder #(.N_I(NI), .K(K), .MAX_IMG_W(64), .MAX_IMG_H(64)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .img_width_i(img_width_i), .img_height_i(img_height_i),
        .padding_i(padding_i), .stride_i(stride_i),
        .pixel_i(pixel_i), .pixel_valid_i(pixel_valid_i), .pixel_ready_o(pixel_ready_o),
        .tb_data_o(tb_data_o), .tb_save_enable_o(tb_save_enable_o), .tb_flush_o(tb_flush_o),
        .window_valid_o(window_valid_o), .window_ready_i(window_ready_i),
        .window_col_o(window_col_o), .window_row_o(window_row_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    // shift tile buffer: oldest pixel in the top byte
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) tbuf <= '0;
        else if (tb_flush_o) tbuf <= '0;
        else if (tb_save_enable_o) tbuf <= {tbuf[DW-PW-1:0], tb_data_o};
    end

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // monitor: handshake stability, stall behaviour and scoreboard comparison
    always @(negedge clk) begin
        if (!rst_ni) begin
            hold = 1'b0;
        end else begin
            if (tb_flush_o) begin
                flush_cnt++;
                check(!tb_save_enable_o, "flush_with_save", tb_save_enable_o, 0);
            end
            if (done_o) done_cnt++;
            if (pixel_ready_o) idx++;
            if (hold)
                check(window_valid_o && window_row_o == held.row && window_col_o == held.col && tbuf == held.data,
                      "held_window_stable", {window_valid_o, window_row_o, window_col_o, tbuf},
                      {1'b1, held.row, held.col, held.data});
            if (window_valid_o && !window_ready_i) begin
                check(!pixel_ready_o && !tb_save_enable_o, "stall_no_push", {pixel_ready_o, tb_save_enable_o}, 0);
                hold = 1'b1;
                held = '{row: window_row_o, col: window_col_o, data: tbuf};
            end else begin
                hold = 1'b0;
            end
            if (window_valid_o && window_ready_i) begin
                if (exp_q.size() == 0) begin
                    check(0, "unexpected_window", {window_row_o, window_col_o, tbuf}, 0);
                end else begin
                    win_t e;
                    e = exp_q.pop_front();
                    check(window_row_o == e.row && window_col_o == e.col && tbuf == e.data, "window",
                          {window_row_o, window_col_o, tbuf}, e);
                end
            end
        end
    end

    task automatic run_image(input int w, input int h, input int pad, input int s, input int gap, input int rdy);
        int st, l, cyc, total;
        logic [DW-1:0] d;
        logic [PW-1:0] px;
        logic [PW-1:0] p[$];
        st = (s == 2) ? 2 : 1;
        l = w + (pad != 0 ? 2 * (K / 2) : 0);
        stream.delete();
        for (int r = 0; r < h; r++) begin
            p.delete();
            if (pad != 0) for (int j = 0; j < K / 2; j++) p.push_back('0);
            for (int c = 0; c < w; c++) begin
                px = PW'($urandom);
                stream.push_back(px);
                p.push_back(px);
            end
            if (pad != 0) for (int j = 0; j < K / 2; j++) p.push_back('0);
            for (int x = 0; x + K <= l; x += st) begin
                d = '0;
                for (int j = 0; j < K; j++) d = (d << PW) | DW'(p[x + j]);
                exp_q.push_back('{row: RW'(r), col: CW'(x / st), data: d});
            end
        end
        total = w * h;
        idx = 0;
        flush_cnt = 0;
        done_cnt = 0;
        @(posedge clk); #1;
        img_width_i = CW'(w);
        img_height_i = RW'(h);
        padding_i = pad != 0;
        stride_i = 2'(s);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc = 0;
        while (done_cnt == 0 && !abort && cyc < LIMIT) begin
            pixel_valid_i = (idx < total) && ($urandom_range(99) >= gap);
            pixel_i = (idx < total) ? stream[idx] : PW'($urandom);
            window_ready_i = $urandom_range(99) >= rdy;
            @(posedge clk); #1;
            cyc++;
        end
        pixel_valid_i = 1'b0;
        window_ready_i = 1'b0;
        if (!abort) begin
            check(cyc < LIMIT, "image_timeout", cyc, LIMIT);
            check(exp_q.size() == 0, "windows_missing", exp_q.size(), 0);
            check(idx == total, "pixels_consumed", idx, total);
            check(flush_cnt == h, "flush_count", flush_cnt, h);
            @(negedge clk);
            check(done_cnt == 1 && !done_o && !busy_o, "done_pulse", {done_cnt[7:0], done_o, busy_o}, {8'd1, 2'b00});
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        abort = 0;
        hold = 0;
        #1;
        check({pixel_ready_o, tb_save_enable_o, tb_flush_o, window_valid_o, busy_o, done_o} == 0
              && tb_data_o == 0 && window_col_o == 0 && window_row_o == 0, "reset_outputs",
              {pixel_ready_o, tb_save_enable_o, tb_flush_o, window_valid_o, busy_o, done_o}, 0);
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        check(!busy_o && !window_valid_o, "idle_after_reset", {busy_o, window_valid_o}, 0);

        run_image(5, 1, 0, 1, 0, 0);
        run_image(4, 1, 1, 1, 0, 0);
        run_image(5, 1, 1, 2, 0, 0);
        run_image(6, 2, 0, 1, 0, 60);
        run_image(7, 3, 1, 2, 40, 30);
        run_image(1, 2, 0, 1, 30, 0);
        run_image(1, 2, 1, 2, 0, 0);
        run_image(2, 1, 1, 3, 0, 0);
        run_image(2, 1, 0, 0, 0, 0);
        run_image(64, 1, 1, 2, 20, 20);
        repeat (6) run_image(int'($urandom_range(1, 12)), int'($urandom_range(1, 3)), int'($urandom_range(0, 1)),
                             int'($urandom_range(0, 3)), int'($urandom_range(0, 50)), int'($urandom_range(0, 50)));

        flush_cnt = 0;
        fork
            run_image(6, 3, 1, 1, 20, 20);
            begin
                int n;
                n = 0;
                while (flush_cnt < 2 && n < LIMIT) begin
                    @(negedge clk);
                    n++;
                end
                check(n < LIMIT, "reach_row1", n, LIMIT);
                repeat (3) @(negedge clk);
                #2 rst_ni = 1'b0;
                abort = 1;
                #1;
                check({pixel_ready_o, tb_save_enable_o, tb_flush_o, window_valid_o, busy_o, done_o} == 0
                      && tb_data_o == 0 && window_col_o == 0 && window_row_o == 0, "midrow_reset_outputs",
                      {pixel_ready_o, tb_save_enable_o, tb_flush_o, window_valid_o, busy_o, done_o}, 0);
            end
        join
        exp_q.delete();
        @(negedge clk);
        check(!busy_o && !done_o && !window_valid_o, "reset_held_idle", {busy_o, done_o, window_valid_o}, 0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        abort = 0;
        run_image(6, 3, 1, 1, 20, 20);
        run_image(5, 2, 0, 2, 10, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
